wta_threshold_ctrl: RTL and testbench
=====================================

# wta_threshold_ctrl

Winner-take-all scheduler and threshold adapter for a layer of `neuron_6in` neurons. On each input event it waits for the synapse traces to settle and scans every neuron's thresholded output. It then fires a one-cycle spike toward the winning neuron (latching its `o_lv`) and moves that neuron's threshold toward the winning potential. It sits between the input event fabric and the neuron array and owns all per-neuron `i_threshold` values.

## Interface
- `p_neurons`, default 4: neurons in the layer (2..16).
- `p_value_width`, default 20: width of a neuron `o_neuron_out` (input width + weight width + 4).
- `p_settle_cycles`, default 2: cycles waited after an event before scanning (1..15).
- `p_eta_shift`, default 3: learning-rate right shift for adaptation and decay (0..7).
- `p_thr_init`, default 256: reset threshold for every neuron.
- `p_thr_min`, default 16: lower bound for decayed thresholds.

Ports:
- `i_clk` in 1: clock.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_event_valid` in 1: any input event delivered to the layer this cycle.
- `i_decay_tick` in 1: periodic threshold-decay request; only used when `WTA_THR_DECAY_EN` is defined.
- `i_neuron_out` in `p_neurons*p_value_width`: packed `o_neuron_out`, neuron 0 in the LSBs.
- `o_threshold` out `p_neurons*(p_value_width-1)`: packed thresholds driving each neuron `i_threshold`.
- `o_spike` out `p_neurons`: one-hot one-cycle pulse to the winner's `i_spike`.
- `o_winner` out `$clog2(p_neurons)`: index of the last winner; held until the next fire.
- `o_fire` out 1: one-cycle pulse, asserted together with `o_spike`.
- `o_no_fire` out 1: one-cycle pulse when a scan finds no candidate.
- `o_busy` out 1: high in every state except IDLE.
- `o_drop` out 1: one-cycle pulse when an event is discarded.

## Operation
- FSM states: IDLE, SETTLE, SCAN, FIRE, ADAPT.
- IDLE:
  - An event, or the pending flag, moves the FSM to SETTLE and clears pending.
  - The settle counter loads `p_settle_cycles-1`.
- SETTLE: counts down; at 0 the FSM moves to SCAN with the scan index at 0, best value 0 and best index 0.
- SCAN:
  - One neuron per cycle, index 0 up to `p_neurons-1`.
  - A neuron is a candidate if its value is nonzero. The neuron gates its own output against threshold, so no compare is done here.
  - The best is replaced only on strictly greater, so ties go to the lowest index.
  - After the last index: FIRE if best > 0, else IDLE with `o_no_fire`.
- FIRE: `o_spike[best_idx]=1`, `o_fire=1`, `o_winner<=best_idx`; next state ADAPT.
- ADAPT:
  - `thr[w] <= thr[w] + ((best - thr[w]) >> p_eta_shift)`.
  - best > thr[w] is guaranteed, so the difference is unsigned.
  - The result saturates at `2^(p_value_width-1)-1`.
  - Next state IDLE.
- Events while busy:
  - The first sets the one-deep pending flag.
  - Each further event while pending is set pulses `o_drop`.
  - An event in the same cycle that IDLE consumes pending sets pending again.
- Arithmetic: thresholds are `p_value_width-1` bits unsigned; the difference is computed at `p_value_width` bits; no wrap-around is permitted.

## Timing
- Event sampled at edge k:
  - SETTLE occupies k+1 .. k+`p_settle_cycles`.
  - SCAN occupies the next `p_neurons` cycles.
  - `o_spike`/`o_fire` are high in cycle k+`p_settle_cycles`+`p_neurons`+1.
  - ADAPT runs the cycle after; the new threshold is visible on `o_threshold` one cycle later.
- Defaults: spike at k+7, updated threshold at k+9, FSM back in IDLE at k+9.
- All outputs are registered.
- Reset values:
  - State IDLE.
  - All thresholds `p_thr_init`.
  - `o_spike`, `o_fire`, `o_no_fire`, `o_drop`, `o_busy`, `o_winner` all 0.
  - Pending flags cleared.
- Reset mid-operation aborts immediately. No spike or threshold update is emitted afterward.

## Configuration
- `WTA_THR_DECAY_EN` defined:
  - `i_decay_tick` sets a one-deep decay-pending flag.
  - In IDLE with decay pending and no event pending, every `thr[i] <= max(thr[i] - (thr[i] >> p_eta_shift), p_thr_min)` for one cycle, which clears the flag.
  - Event pending has priority over decay.
- Undefined: `i_decay_tick` is ignored and thresholds change only in ADAPT.

## Structure
- Package `wta_pkg`:
  - State enum (IDLE, SETTLE, SCAN, FIRE, ADAPT).
  - Saturation constant function for threshold max.
  - Helper to slice packed neuron vectors.
- One sub-module, `thr_update`: combinational adapt/decay arithmetic with saturation and floor, instantiated once and muxed by state.

## Test plan
- Defaults. Event with `i_neuron_out` = {0, 400, 0, 0} (n3..n0) -> `o_spike`=4'b0010 at k+7; `o_winner`=1; thr[1] = 256+((400-256)>>3) = 274 at k+9; other thresholds stay 256.
- Event with all outputs 0 -> `o_no_fire` at k+7, no spike, thresholds unchanged.
- Tie: n0=n2=500 -> winner 0; thr[0] = 256+30 = 286.
- Three events at k, k+1, k+2 -> second processed back-to-back after the first; third pulses `o_drop` at k+2.
- `i_rst` asserted at k+4 of a scan -> outputs 0 at once, thresholds 256, no spike afterward.
- `WTA_THR_DECAY_EN`:
  - Decay tick in IDLE with thr=256 -> 224.
  - Repeated ticks floor at 16.
  - Macro undefined -> stays 256.

Source files
------------

// File: rtl/wta_threshold_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// wta_pkg
// Shared types and helpers for the winner-take-all threshold controller.
//   wta_state_e : controller FSM states
//   upd_mode_e  : selects adapt (winner only) or decay (all neurons) arithmetic
//   thr_max()   : largest value a threshold register may hold
//   slice_val() : extracts one neuron value from a packed neuron vector
// ---------------------------------------------------------------------------
package wta_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_SCAN   = 3'd2,
      ST_FIRE   = 3'd3,
      ST_ADAPT  = 3'd4
   } wta_state_e;

   typedef enum logic {
      UPD_ADAPT = 1'b0,
      UPD_DECAY = 1'b1
   } upd_mode_e;

   // Thresholds are one bit narrower than the neuron value width.
   function automatic logic [31:0] thr_max(input int w);
      return (32'd1 << (w - 1)) - 32'd1;
   endfunction

   // Packed vectors up to 512 bits (16 neurons x 32 bits) are supported.
   function automatic logic [31:0] slice_val(input logic [511:0] vec,
                                              input int idx,
                                              input int w);
      return 32'((vec >> (idx * w)) & ((512'(1) << w) - 512'(1)));
   endfunction

endpackage

// File: rtl/wta_threshold_ctrl_if.sv
// ---------------------------------------------------------------------------
// wta_threshold_ctrl_if
// Groups the event fabric inputs and the neuron-array facing outputs.
//   i_event_valid : input event strobe (valid-only, see below)
//   i_decay_tick  : threshold decay request
//   i_neuron_out  : packed neuron outputs, neuron 0 in the LSBs
//   o_threshold   : packed per-neuron thresholds
//   o_spike       : one-hot winner pulse
//   o_winner      : last winner index
//   o_fire / o_no_fire / o_busy / o_drop : status pulses and level
//   dbg_state     : controller FSM state
// Handshake: i_event_valid has no ready. An event is taken when the
// controller is idle, parked in a one-deep pending slot while busy, and
// discarded (o_drop pulse) when the slot is already occupied.
// ---------------------------------------------------------------------------
interface wta_threshold_ctrl_if #(
   parameter int p_neurons     = 4,
   parameter int p_value_width = 20
);
   import wta_pkg::*;

   logic                                     i_event_valid;
   logic                                     i_decay_tick;
   logic [p_neurons*p_value_width-1:0]       i_neuron_out;
   logic [p_neurons*(p_value_width-1)-1:0]   o_threshold;
   logic [p_neurons-1:0]                     o_spike;
   logic [$clog2(p_neurons)-1:0]             o_winner;
   logic                                     o_fire;
   logic                                     o_no_fire;
   logic                                     o_busy;
   logic                                     o_drop;
   wta_state_e                               dbg_state;

   modport master (
      output i_event_valid, i_decay_tick, i_neuron_out,
      input  o_threshold, o_spike, o_winner, o_fire, o_no_fire, o_busy,
             o_drop, dbg_state
   );

   modport slave (
      input  i_event_valid, i_decay_tick, i_neuron_out,
      output o_threshold, o_spike, o_winner, o_fire, o_no_fire, o_busy,
             o_drop, dbg_state
   );

endinterface

// File: rtl/wta_threshold_ctrl_thr_update.sv
// ---------------------------------------------------------------------------
// thr_update
// Combinational next-threshold arithmetic for the whole layer.
//   i_thr     : current packed thresholds
//   i_best    : winning potential
//   i_win_idx : winner index (adapt mode)
//   i_mode    : UPD_ADAPT moves the winner toward i_best, saturating;
//               UPD_DECAY shrinks every threshold, floored at p_thr_min
//   o_thr     : next packed thresholds
// ---------------------------------------------------------------------------
module thr_update
   import wta_pkg::*;
#(
   parameter int p_neurons     = 4,
   parameter int p_value_width = 20,
   parameter int p_eta_shift   = 3,
   parameter int p_thr_min     = 16
) (
   input  logic [p_neurons*(p_value_width-1)-1:0] i_thr,
   input  logic [p_value_width-1:0]               i_best,
   input  logic [$clog2(p_neurons)-1:0]           i_win_idx,
   input  upd_mode_e                              i_mode,
   output logic [p_neurons*(p_value_width-1)-1:0] o_thr
);
   localparam int TW = p_value_width - 1;
   localparam int IW = $clog2(p_neurons);
   localparam logic [TW-1:0] THR_MAX = TW'(thr_max(p_value_width));
   localparam logic [TW-1:0] FLOOR   = TW'(p_thr_min);

   for (genvar i = 0; i < p_neurons; i++) begin : g_n
      logic [TW-1:0]            t;
      logic [p_value_width-1:0] t_ext;
      logic [p_value_width-1:0] diff;
      logic [p_value_width-1:0] sum;
      logic [TW-1:0]            dec;
      logic [TW-1:0]            nxt;

      assign t     = i_thr[i*TW +: TW];
      assign t_ext = {1'b0, t};
      // Clamp at zero so a stale or equal best can never wrap the difference.
      assign diff  = (i_best > t_ext) ? (i_best - t_ext) : '0;
      // sum never exceeds i_best, so p_value_width bits cannot overflow.
      assign sum   = t_ext + (diff >> p_eta_shift);
      assign dec   = t - (t >> p_eta_shift);

      always_comb begin
         nxt = t;
         if (i_mode == UPD_ADAPT) begin
            if (i_win_idx == IW'(i))
               nxt = (sum > {1'b0, THR_MAX}) ? THR_MAX : sum[TW-1:0];
         end else begin
            nxt = (dec < FLOOR) ? FLOOR : dec;
         end
      end

      assign o_thr[i*TW +: TW] = nxt;
   end

endmodule

// File: rtl/wta_threshold_ctrl.sv
// ---------------------------------------------------------------------------
// wta_threshold_ctrl
// Winner-take-all scheduler and threshold adapter for a neuron layer.
// After each input event it waits p_settle_cycles, scans one neuron per
// cycle for the largest nonzero output (ties to the lowest index), pulses
// the winner's spike, then moves the winner's threshold toward the winning
// potential.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus          : wta_threshold_ctrl_if.slave (events, neuron values,
//                  thresholds, spike/status outputs, FSM state)
// Optional feature: define WTA_THR_DECAY_EN to let i_decay_tick shrink all
// thresholds while idle; otherwise i_decay_tick is ignored.
// ---------------------------------------------------------------------------
module wta_threshold_ctrl
   import wta_pkg::*;
#(
   parameter int p_neurons       = 4,
   parameter int p_value_width   = 20,
   parameter int p_settle_cycles = 2,
   parameter int p_eta_shift     = 3,
   parameter int p_thr_init      = 256,
   parameter int p_thr_min       = 16
) (
   input logic                 i_clk,
   input logic                 i_rst,
   wta_threshold_ctrl_if.slave bus
);
   localparam int IW = $clog2(p_neurons);
   localparam int TW = p_value_width - 1;

   wta_state_e                  state;
   logic [3:0]                  settle_cnt;
   logic [IW-1:0]               scan_idx;
   logic [IW-1:0]               best_idx;
   logic [IW-1:0]               winner;
   logic [p_value_width-1:0]    best_val;
   logic [p_value_width-1:0]    cur_val;
   logic                        better;
   logic [p_value_width-1:0]    nxt_best_val;
   logic [IW-1:0]               nxt_best_idx;
   logic [p_neurons-1:0]        spike;
   logic                        fire;
   logic                        no_fire;
   logic                        busy;
   logic                        drop;
   logic                        pending;
   logic [p_neurons*TW-1:0]     thr_q;
   logic [p_neurons*TW-1:0]     thr_next;
   upd_mode_e                   upd_mode;

   assign cur_val = p_value_width'(slice_val(512'(bus.i_neuron_out),
                                             32'(scan_idx), p_value_width));
   // Strictly greater keeps the earliest (lowest index) of equal values;
   // best_val starts at 0 so zero outputs never become candidates.
   assign better       = cur_val > best_val;
   assign nxt_best_val = better ? cur_val  : best_val;
   assign nxt_best_idx = better ? scan_idx : best_idx;

`ifdef WTA_THR_DECAY_EN
   logic decay_pend;
   assign upd_mode = (state == ST_ADAPT) ? UPD_ADAPT : UPD_DECAY;
`else
   logic unused_decay_tick;
   assign unused_decay_tick = bus.i_decay_tick;
   assign upd_mode          = UPD_ADAPT;
`endif

   thr_update #(
      .p_neurons    (p_neurons),
      .p_value_width(p_value_width),
      .p_eta_shift  (p_eta_shift),
      .p_thr_min    (p_thr_min)
   ) u_thr_update (
      .i_thr    (thr_q),
      .i_best   (best_val),
      .i_win_idx(winner),
      .i_mode   (upd_mode),
      .o_thr    (thr_next)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state      <= ST_IDLE;
         settle_cnt <= '0;
         scan_idx   <= '0;
         best_idx   <= '0;
         best_val   <= '0;
         winner     <= '0;
         spike      <= '0;
         fire       <= 1'b0;
         no_fire    <= 1'b0;
         busy       <= 1'b0;
         drop       <= 1'b0;
         pending    <= 1'b0;
         thr_q      <= {p_neurons{TW'(p_thr_init)}};
`ifdef WTA_THR_DECAY_EN
         decay_pend <= 1'b0;
`endif
      end else begin
         spike   <= '0;
         fire    <= 1'b0;
         no_fire <= 1'b0;
         drop    <= 1'b0;

         if (bus.i_event_valid && (state != ST_IDLE)) begin
            if (pending) drop    <= 1'b1;
            else         pending <= 1'b1;
         end
`ifdef WTA_THR_DECAY_EN
         if (bus.i_decay_tick) decay_pend <= 1'b1;
`endif

         case (state)
            ST_IDLE: begin
               if (pending || bus.i_event_valid) begin
                  state      <= ST_SETTLE;
                  settle_cnt <= 4'(p_settle_cycles - 1);
                  busy       <= 1'b1;
                  // Consuming the pending event while a new one arrives
                  // re-arms the slot with the new event.
                  pending    <= pending & bus.i_event_valid;
               end
`ifdef WTA_THR_DECAY_EN
               else if (decay_pend) begin
                  thr_q      <= thr_next;
                  decay_pend <= bus.i_decay_tick;
               end
`endif
            end
            ST_SETTLE: begin
               if (settle_cnt == 4'd0) begin
                  state    <= ST_SCAN;
                  scan_idx <= '0;
                  best_val <= '0;
                  best_idx <= '0;
               end else begin
                  settle_cnt <= settle_cnt - 4'd1;
               end
            end
            ST_SCAN: begin
               best_val <= nxt_best_val;
               best_idx <= nxt_best_idx;
               if (scan_idx == IW'(p_neurons - 1)) begin
                  // Spike is registered on entry so it coincides with FIRE.
                  if (nxt_best_val != '0) begin
                     state  <= ST_FIRE;
                     spike  <= {{(p_neurons-1){1'b0}}, 1'b1} << nxt_best_idx;
                     fire   <= 1'b1;
                     winner <= nxt_best_idx;
                  end else begin
                     state   <= ST_IDLE;
                     no_fire <= 1'b1;
                     busy    <= 1'b0;
                  end
               end else begin
                  scan_idx <= scan_idx + 1'b1;
               end
            end
            ST_FIRE: begin
               state <= ST_ADAPT;
            end
            ST_ADAPT: begin
               thr_q <= thr_next;
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_threshold = thr_q;
   assign bus.o_spike     = spike;
   assign bus.o_winner    = winner;
   assign bus.o_fire      = fire;
   assign bus.o_no_fire   = no_fire;
   assign bus.o_busy      = busy;
   assign bus.o_drop      = drop;
   assign bus.dbg_state   = state;

endmodule

// File: tb/tb_wta_threshold_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wta_threshold_ctrl
// Self-checking bench for wta_threshold_ctrl at default parameters.
// Builds with or without WTA_THR_DECAY_EN.
// ---------------------------------------------------------------------------
module tb_wta_threshold_ctrl;
   import wta_pkg::*;

   localparam int N   = 4;
   localparam int W   = 20;
   localparam int TW  = W - 1;
   localparam int IW  = 2;
   localparam int SBW = 2 + IW + N;
   localparam int THR_MAX_M = 524287;

   logic i_clk = 1'b0;
   logic i_rst;

   wta_threshold_ctrl_if #(.p_neurons(N), .p_value_width(W)) bus ();

   wta_threshold_ctrl #(
      .p_neurons(N), .p_value_width(W), .p_settle_cycles(2),
      .p_eta_shift(3), .p_thr_init(256), .p_thr_min(16)
   ) dut (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .bus  (bus)
   );

   // ---------------- clock ----------------
   always #5 i_clk = ~i_clk;

   int total = 0;
   int bad   = 0;
   logic [SBW-1:0] exp_q[$];

   int thr_m[N];
   int nv[N];
   int last_win = 0;

   // ---------------- model ----------------
   function automatic logic [N*TW-1:0] pack_thr();
      logic [N*TW-1:0] r;
      for (int i = 0; i < N; i++) r[i*TW +: TW] = TW'(thr_m[i]);
      return r;
   endfunction

   function automatic logic [N*W-1:0] pack_nv();
      logic [N*W-1:0] r;
      for (int i = 0; i < N; i++) r[i*W +: W] = W'(nv[i]);
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) thr_m[i] = 256;
      last_win = 0;
   endtask

   // Winner search and threshold move for one event; pushes the expected
   // {fire, no_fire, winner, spike} observed when the scan completes.
   task automatic model_push();
      int best;
      int bi;
      int t;
      logic [N-1:0] sp;
      best = 0;
      bi   = 0;
      for (int i = 0; i < N; i++)
         if (nv[i] > best) begin best = nv[i]; bi = i; end
      if (best > 0) begin
         last_win = bi;
         sp = '0;
         sp[bi] = 1'b1;
         t = thr_m[bi] + ((best - thr_m[bi]) >>> 3);
         thr_m[bi] = (t > THR_MAX_M) ? THR_MAX_M : t;
         exp_q.push_back({1'b1, 1'b0, IW'(bi), sp});
      end else begin
         exp_q.push_back({1'b0, 1'b1, IW'(last_win), {N{1'b0}}});
      end
   endtask

   // ---------------- driver ----------------
   // Returns #1 after the edge that samples the event (edge k).
   task automatic pulse_event();
      @(negedge i_clk);
      bus.i_neuron_out  = pack_nv();
      bus.i_event_valid = 1'b1;
      @(posedge i_clk);
      #1;
      bus.i_event_valid = 1'b0;
   endtask

   task automatic clear_nv();
      for (int i = 0; i < N; i++) nv[i] = 0;
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge i_clk) begin
      if (!i_rst && (bus.o_fire || bus.o_no_fire)) begin
         logic [SBW-1:0] got;
         logic [SBW-1:0] exp;
         got = {bus.o_fire, bus.o_no_fire, bus.o_winner, bus.o_spike};
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: got=%b required=no output", got);
         end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
               bad++;
               $display("FAIL sb_result: got=%b required=%b", got, exp);
            end
         end
      end
   end

   // ---------------- tests ----------------
   task automatic test_reset();
      total++;
      if ({bus.o_spike, bus.o_fire, bus.o_no_fire, bus.o_drop, bus.o_busy,
           bus.o_winner} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got=%b required=0",
                  {bus.o_spike, bus.o_fire, bus.o_no_fire, bus.o_drop,
                   bus.o_busy, bus.o_winner});
      end
      total++;
      if (bus.o_threshold !== pack_thr()) begin
         bad++;
         $display("FAIL reset_thr: got=%h required=%h", bus.o_threshold, pack_thr());
      end
      total++;
      if (bus.dbg_state !== ST_IDLE) begin
         bad++;
         $display("FAIL reset_state: got=%0d required=%0d", bus.dbg_state, ST_IDLE);
      end
   endtask

   task automatic test_single_winner();
      clear_nv();
      nv[1] = 400;
      model_push();
      pulse_event();
      repeat (5) @(posedge i_clk);
      #1;
      total++;
      if (bus.o_fire !== 1'b0) begin
         bad++;
         $display("FAIL single_early_fire: got=%b required=0", bus.o_fire);
      end
      @(posedge i_clk);
      #1;
      total++;
      if ({bus.o_fire, bus.o_spike, bus.o_winner} !== {1'b1, 4'b0010, 2'd1}) begin
         bad++;
         $display("FAIL single_spike: got=%b required=%b",
                  {bus.o_fire, bus.o_spike, bus.o_winner}, {1'b1, 4'b0010, 2'd1});
      end
      repeat (2) @(posedge i_clk);
      #1;
      total++;
      if (bus.o_threshold !== pack_thr() || thr_m[1] != 274) begin
         bad++;
         $display("FAIL single_thr: got=%h required=%h", bus.o_threshold, pack_thr());
      end
      total++;
      if ({bus.o_busy, bus.dbg_state} !== {1'b0, ST_IDLE}) begin
         bad++;
         $display("FAIL single_idle: got busy=%b state=%0d required busy=0 state=0",
                  bus.o_busy, bus.dbg_state);
      end
   endtask

   task automatic test_no_fire();
      clear_nv();
      model_push();
      pulse_event();
      repeat (6) @(posedge i_clk);
      #1;
      total++;
      if ({bus.o_no_fire, bus.o_fire, bus.o_spike} !== {1'b1, 1'b0, 4'b0000}) begin
         bad++;
         $display("FAIL nofire_pulse: got=%b required=%b",
                  {bus.o_no_fire, bus.o_fire, bus.o_spike}, 6'b100000);
      end
      repeat (3) @(posedge i_clk);
      #1;
      total++;
      if (bus.o_threshold !== pack_thr()) begin
         bad++;
         $display("FAIL nofire_thr: got=%h required=%h", bus.o_threshold, pack_thr());
      end
   endtask

   task automatic test_tie();
      clear_nv();
      nv[0] = 500;
      nv[2] = 500;
      model_push();
      pulse_event();
      repeat (8) @(posedge i_clk);
      #1;
      total++;
      if (bus.o_winner !== 2'd0) begin
         bad++;
         $display("FAIL tie_winner: got=%0d required=0", bus.o_winner);
      end
      total++;
      if (bus.o_threshold !== pack_thr() || thr_m[0] != 286) begin
         bad++;
         $display("FAIL tie_thr: got=%h required=%h", bus.o_threshold, pack_thr());
      end
   endtask

   task automatic test_back_to_back();
      clear_nv();
      nv[3] = 600;
      model_push();
      model_push();
      @(negedge i_clk);
      bus.i_neuron_out  = pack_nv();
      bus.i_event_valid = 1'b1;
      @(posedge i_clk);                 // edge k
      @(posedge i_clk);                 // edge k+1: pending set
      #1;
      total++;
      if ({bus.o_drop, bus.o_busy} !== 2'b01) begin
         bad++;
         $display("FAIL b2b_second: got drop,busy=%b required=01",
                  {bus.o_drop, bus.o_busy});
      end
      @(posedge i_clk);                 // edge k+2: third event dropped
      #1;
      bus.i_event_valid = 1'b0;
      total++;
      if (bus.o_drop !== 1'b1) begin
         bad++;
         $display("FAIL b2b_drop: got=%b required=1", bus.o_drop);
      end
      @(posedge i_clk);
      #1;
      total++;
      if (bus.o_drop !== 1'b0) begin
         bad++;
         $display("FAIL b2b_drop_width: got=%b required=0", bus.o_drop);
      end
      repeat (12) @(posedge i_clk);     // edge k+15
      #1;
      total++;
      if ({bus.o_fire, bus.o_spike} !== {1'b1, 4'b1000}) begin
         bad++;
         $display("FAIL b2b_second_spike: got=%b required=%b",
                  {bus.o_fire, bus.o_spike}, 5'b11000);
      end
      repeat (2) @(posedge i_clk);
      #1;
      total++;
      if (bus.o_threshold !== pack_thr() || thr_m[3] != 336) begin
         bad++;
         $display("FAIL b2b_thr: got=%h required=%h", bus.o_threshold, pack_thr());
      end
   endtask

   task automatic test_reset_mid_scan();
      clear_nv();
      nv[1] = 900;
      pulse_event();
      repeat (4) @(posedge i_clk);
      #1;
      i_rst = 1'b1;
      model_reset();
      #1;
      test_reset();
      @(negedge i_clk);
      i_rst = 1'b0;
      repeat (12) @(posedge i_clk);
      #1;
      total++;
      if ({bus.o_busy, bus.o_threshold} !== {1'b0, pack_thr()}) begin
         bad++;
         $display("FAIL rst_mid_after: got busy=%b thr=%h required busy=0 thr=%h",
                  bus.o_busy, bus.o_threshold, pack_thr());
      end
   endtask

   task automatic test_saturation();
      clear_nv();
      nv[2] = 20'hFFFFF;
      for (int n = 0; n < 6; n++) begin
         model_push();
         pulse_event();
         repeat (9) @(posedge i_clk);
         #1;
         total++;
         if (bus.o_threshold !== pack_thr()) begin
            bad++;
            $display("FAIL sat_thr%0d: got=%h required=%h", n, bus.o_threshold, pack_thr());
         end
      end
      total++;
      if (bus.o_threshold[2*TW +: TW] !== 19'h7FFFF) begin
         bad++;
         $display("FAIL sat_max: got=%h required=7ffff", bus.o_threshold[2*TW +: TW]);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 8; n++) begin
         for (int i = 0; i < N; i++)
            nv[i] = ($urandom_range(0, 2) == 0) ? 0 : thr_m[i] + int'($urandom_range(1, 500));
         model_push();
         pulse_event();
         repeat (9) @(posedge i_clk);
         #1;
         total++;
         if (bus.o_threshold !== pack_thr()) begin
            bad++;
            $display("FAIL rand_thr%0d: got=%h required=%h", n, bus.o_threshold, pack_thr());
         end
      end
   endtask

   task automatic pulse_tick();
      @(negedge i_clk);
      bus.i_decay_tick = 1'b1;
      @(negedge i_clk);
      bus.i_decay_tick = 1'b0;
      @(negedge i_clk);
   endtask

   task automatic test_decay();
      @(negedge i_clk);
      i_rst = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0;
      model_reset();
      clear_nv();
      bus.i_neuron_out = pack_nv();
      pulse_tick();
`ifdef WTA_THR_DECAY_EN
      for (int i = 0; i < N; i++) thr_m[i] = 224;
`endif
      total++;
      if (bus.o_threshold !== pack_thr()) begin
         bad++;
         $display("FAIL decay_first: got=%h required=%h", bus.o_threshold, pack_thr());
      end
      for (int n = 0; n < 30; n++) pulse_tick();
`ifdef WTA_THR_DECAY_EN
      for (int i = 0; i < N; i++) thr_m[i] = 16;
`endif
      total++;
      if (bus.o_threshold !== pack_thr()) begin
         bad++;
         $display("FAIL decay_floor: got=%h required=%h", bus.o_threshold, pack_thr());
      end
   endtask

   // ---------------- sequence ----------------
   initial begin
      i_rst             = 1'b1;
      bus.i_event_valid = 1'b0;
      bus.i_decay_tick  = 1'b0;
      bus.i_neuron_out  = '0;
      model_reset();
      clear_nv();
      repeat (2) @(posedge i_clk);
      #1;
      test_reset();
      @(negedge i_clk);
      i_rst = 1'b0;
      repeat (2) @(posedge i_clk);

      test_single_winner();
      test_no_fire();
      test_tie();
      test_back_to_back();
      test_reset_mid_scan();
      test_saturation();
      test_random();
      test_decay();

      repeat (4) @(posedge i_clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL sb_leftover: got=%0d pending required=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
